// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC select and IF/ID pipeline register.
// Optional fetch/stall performance counters are enabled by defining IF_PERF_CNT_EN.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        Reset,
   input  logic        Stall,
   input  logic        Flush,
   input  logic        BranchTaken,
   input  logic [31:0] BranchTarget,
   input  logic        Jump,
   input  logic [25:0] JumpAddr,
   input  logic [31:0] Instr,
   output logic [7:0]  ImAdr,
   output logic [31:0] PC,
   output logic [31:0] IfId_Instr,
   output logic [31:0] IfId_Pc4,
   output logic        IfId_Valid
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] FetchCnt,
   output logic [31:0] StallCnt
`endif
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] pc_plus4;
   logic [31:0] ifid_instr_q, ifid_instr_d;
   logic [31:0] ifid_pc4_q, ifid_pc4_d;
   logic        ifid_valid_q, ifid_valid_d;
   logic        redirect;
   logic        bubble;
   logic        load;
   logic        unused_target_bits;

   assign unused_target_bits = ^BranchTarget[1:0];

   always_comb begin
      pc_plus4 = pc_q + 32'd4;
      redirect = BranchTaken | Jump;
      // A stalled redirect is dropped; the decode stage re-presents it next cycle.
      bubble   = Flush | (redirect & ~Stall);
      load     = ~bubble & ~Stall;

      pc_d = pc_plus4;
      if (Stall)
         pc_d = pc_q;
      else if (BranchTaken)
         pc_d = {BranchTarget[31:2], 2'b00};
      else if (Jump)
         pc_d = {ifid_pc4_q[31:28], JumpAddr, 2'b00};

      ifid_instr_d = ifid_instr_q;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_valid_d = ifid_valid_q;
      if (bubble) begin
         ifid_instr_d = NOP_WORD;
         ifid_pc4_d   = '0;
         ifid_valid_d = 1'b0;
      end else if (load) begin
         ifid_instr_d = Instr;
         ifid_pc4_d   = pc_plus4;
         ifid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         pc_q         <= RESET_PC;
         ifid_instr_q <= NOP_WORD;
         ifid_pc4_q   <= '0;
         ifid_valid_q <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc4_q   <= ifid_pc4_d;
         ifid_valid_q <= ifid_valid_d;
      end
   end

   assign ImAdr      = pc_q[9:2];
   assign PC         = pc_q;
   assign IfId_Instr = ifid_instr_q;
   assign IfId_Pc4   = ifid_pc4_q;
   assign IfId_Valid = ifid_valid_q;

`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      fetch_cnt_d = fetch_cnt_q + {31'd0, load};
      stall_cnt_d = stall_cnt_q + {31'd0, Stall};
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign FetchCnt = fetch_cnt_q;
   assign StallCnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage with a combinational instruction memory model.
module tb_if_stage;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        flush;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [25:0] jump_addr;
   logic [31:0] instr;
   logic [7:0]  im_adr;
   logic [31:0] pc;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc4;
   logic        ifid_valid;
`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_cnt;
   logic [31:0] stall_cnt;
`endif

   logic [31:0] im [0:255];
   int unsigned checks;
   int unsigned errors;

   if_stage #(
      .RESET_PC(32'h0000_0000),
      .NOP_WORD(32'h0000_0000)
   ) dut (
      .clk         (clk),
      .Reset       (reset),
      .Stall       (stall),
      .Flush       (flush),
      .BranchTaken (branch_taken),
      .BranchTarget(branch_target),
      .Jump        (jump),
      .JumpAddr    (jump_addr),
      .Instr       (instr),
      .ImAdr       (im_adr),
      .PC          (pc),
      .IfId_Instr  (ifid_instr),
      .IfId_Pc4    (ifid_pc4),
      .IfId_Valid  (ifid_valid)
`ifdef IF_PERF_CNT_EN
      ,
      .FetchCnt    (fetch_cnt),
      .StallCnt    (stall_cnt)
`endif
   );

   assign instr = im[im_adr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      stall         = 1'b0;
      flush         = 1'b0;
      branch_taken  = 1'b0;
      branch_target = 32'h0;
      jump          = 1'b0;
      jump_addr     = 26'h0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clear_inputs();
      tick();
      tick();
      checks++;
      if ({pc, ifid_instr, ifid_pc4, ifid_valid, im_adr} !== {32'h0, 32'h0, 32'h0, 1'b0, 8'h00}) begin
         errors++;
         $display("FAIL reset: pc=%h instr=%h pc4=%h v=%b adr=%h want 0/0/0/0/0", pc, ifid_instr, ifid_pc4, ifid_valid, im_adr);
      end
`ifdef IF_PERF_CNT_EN
      checks++;
      if ({fetch_cnt, stall_cnt} !== 64'h0) begin
         errors++;
         $display("FAIL reset_cnt: fetch=%0d stall=%0d want 0/0", fetch_cnt, stall_cnt);
      end
`endif
      reset = 1'b0;
   endtask

   task automatic test_sequential();
      logic [31:0] exp_pc   [3];
      logic [31:0] exp_ins  [3];
      exp_pc  = '{32'h4, 32'h8, 32'hC};
      exp_ins = '{32'h20080001, 32'h20090002, 32'h01095020};
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({pc, ifid_instr, ifid_pc4, ifid_valid} !== {exp_pc[i], exp_ins[i], exp_pc[i], 1'b1}) begin
            errors++;
            $display("FAIL seq%0d: pc=%h instr=%h pc4=%h v=%b want %h/%h/%h/1", i, pc, ifid_instr, ifid_pc4, ifid_valid, exp_pc[i], exp_ins[i], exp_pc[i]);
         end
      end
   endtask

   task automatic test_stall();
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if ({pc, ifid_instr, ifid_pc4, ifid_valid} !== {32'hC, 32'h01095020, 32'hC, 1'b1}) begin
            errors++;
            $display("FAIL stall%0d: pc=%h instr=%h pc4=%h v=%b want c/01095020/c/1", i, pc, ifid_instr, ifid_pc4, ifid_valid);
         end
      end
`ifdef IF_PERF_CNT_EN
      checks++;
      if ({fetch_cnt, stall_cnt} !== {32'd3, 32'd2}) begin
         errors++;
         $display("FAIL stall_cnt: fetch=%0d stall=%0d want 3/2", fetch_cnt, stall_cnt);
      end
`endif
      stall = 1'b0;
      tick();
      checks++;
      if ({pc, ifid_instr, ifid_pc4, ifid_valid} !== {32'h10, 32'hAC0A0000, 32'h10, 1'b1}) begin
         errors++;
         $display("FAIL stall_resume: pc=%h instr=%h pc4=%h v=%b want 10/ac0a0000/10/1", pc, ifid_instr, ifid_pc4, ifid_valid);
      end
   endtask

   task automatic test_branch();
      branch_taken  = 1'b1;
      branch_target = 32'h0000_0043;
      tick();
      clear_inputs();
      checks++;
      if ({pc, ifid_instr, ifid_pc4, ifid_valid, im_adr} !== {32'h40, 32'h0, 32'h0, 1'b0, 8'h10}) begin
         errors++;
         $display("FAIL branch: pc=%h instr=%h pc4=%h v=%b adr=%h want 40/0/0/0/10", pc, ifid_instr, ifid_pc4, ifid_valid, im_adr);
      end
      tick();
      checks++;
      if ({pc, ifid_instr, ifid_pc4, ifid_valid} !== {32'h44, 32'hA0000010, 32'h44, 1'b1}) begin
         errors++;
         $display("FAIL branch_tgt: pc=%h instr=%h pc4=%h v=%b want 44/a0000010/44/1", pc, ifid_instr, ifid_pc4, ifid_valid);
      end
   endtask

   task automatic test_jump();
      jump      = 1'b1;
      jump_addr = 26'h000_0010;
      tick();
      clear_inputs();
      checks++;
      if ({pc, ifid_instr, ifid_pc4, ifid_valid} !== {32'h40, 32'h0, 32'h0, 1'b0}) begin
         errors++;
         $display("FAIL jump: pc=%h instr=%h pc4=%h v=%b want 40/0/0/0", pc, ifid_instr, ifid_pc4, ifid_valid);
      end
      // Jump region bits come from IF/ID PC+4: move into the 0x9xxxxxxx segment first.
      branch_taken  = 1'b1;
      branch_target = 32'h9000_0000;
      tick();
      clear_inputs();
      tick();
      checks++;
      if ({pc, ifid_instr, ifid_pc4, ifid_valid} !== {32'h90000004, 32'h20080001, 32'h90000004, 1'b1}) begin
         errors++;
         $display("FAIL jump_seg_setup: pc=%h instr=%h pc4=%h v=%b want 90000004/20080001/90000004/1", pc, ifid_instr, ifid_pc4, ifid_valid);
      end
      jump      = 1'b1;
      jump_addr = 26'h000_0010;
      tick();
      clear_inputs();
      checks++;
      if ({pc, ifid_valid} !== {32'h90000040, 1'b0}) begin
         errors++;
         $display("FAIL jump_seg: pc=%h v=%b want 90000040/0", pc, ifid_valid);
      end
      branch_taken  = 1'b1;
      branch_target = 32'h0000_0080;
      jump          = 1'b1;
      jump_addr     = 26'h000_0003;
      tick();
      clear_inputs();
      checks++;
      if ({pc, ifid_instr, ifid_pc4, ifid_valid} !== {32'h80, 32'h0, 32'h0, 1'b0}) begin
         errors++;
         $display("FAIL br_jump: pc=%h instr=%h pc4=%h v=%b want 80/0/0/0", pc, ifid_instr, ifid_pc4, ifid_valid);
      end
      tick();
      checks++;
      if ({pc, ifid_instr, ifid_pc4, ifid_valid} !== {32'h84, 32'hA0000020, 32'h84, 1'b1}) begin
         errors++;
         $display("FAIL br_jump_tgt: pc=%h instr=%h pc4=%h v=%b want 84/a0000020/84/1", pc, ifid_instr, ifid_pc4, ifid_valid);
      end
   endtask

   task automatic test_stall_combos();
      stall         = 1'b1;
      branch_taken  = 1'b1;
      branch_target = 32'h0000_0200;
      tick();
      checks++;
      if ({pc, ifid_instr, ifid_pc4, ifid_valid} !== {32'h84, 32'hA0000020, 32'h84, 1'b1}) begin
         errors++;
         $display("FAIL stall_branch: pc=%h instr=%h pc4=%h v=%b want 84/a0000020/84/1", pc, ifid_instr, ifid_pc4, ifid_valid);
      end
      branch_taken = 1'b0;
      flush        = 1'b1;
      tick();
      checks++;
      if ({pc, ifid_instr, ifid_pc4, ifid_valid} !== {32'h84, 32'h0, 32'h0, 1'b0}) begin
         errors++;
         $display("FAIL stall_flush: pc=%h instr=%h pc4=%h v=%b want 84/0/0/0", pc, ifid_instr, ifid_pc4, ifid_valid);
      end
      clear_inputs();
      tick();
      checks++;
      if ({pc, ifid_instr, ifid_pc4, ifid_valid} !== {32'h88, 32'hA0000021, 32'h88, 1'b1}) begin
         errors++;
         $display("FAIL stall_combo_resume: pc=%h instr=%h pc4=%h v=%b want 88/a0000021/88/1", pc, ifid_instr, ifid_pc4, ifid_valid);
      end
      flush = 1'b1;
      tick();
      clear_inputs();
      checks++;
      if ({pc, ifid_instr, ifid_pc4, ifid_valid} !== {32'h8C, 32'h0, 32'h0, 1'b0}) begin
         errors++;
         $display("FAIL flush: pc=%h instr=%h pc4=%h v=%b want 8c/0/0/0", pc, ifid_instr, ifid_pc4, ifid_valid);
      end
      tick();
      checks++;
      if ({pc, ifid_instr, ifid_pc4, ifid_valid} !== {32'h90, 32'hA0000023, 32'h90, 1'b1}) begin
         errors++;
         $display("FAIL flush_resume: pc=%h instr=%h pc4=%h v=%b want 90/a0000023/90/1", pc, ifid_instr, ifid_pc4, ifid_valid);
      end
   endtask

   task automatic test_wrap_and_reset();
      branch_taken  = 1'b1;
      branch_target = 32'hFFFF_FFFF;
      tick();
      clear_inputs();
      checks++;
      if ({pc, im_adr, ifid_valid} !== {32'hFFFFFFFC, 8'hFF, 1'b0}) begin
         errors++;
         $display("FAIL wrap_setup: pc=%h adr=%h v=%b want fffffffc/ff/0", pc, im_adr, ifid_valid);
      end
      tick();
      checks++;
      if ({pc, ifid_instr, ifid_pc4, ifid_valid, im_adr} !== {32'h0, 32'hA00000FF, 32'h0, 1'b1, 8'h00}) begin
         errors++;
         $display("FAIL wrap: pc=%h instr=%h pc4=%h v=%b adr=%h want 0/a00000ff/0/1/00", pc, ifid_instr, ifid_pc4, ifid_valid, im_adr);
      end
      branch_taken  = 1'b1;
      branch_target = 32'h0000_0040;
      tick();
      clear_inputs();
      reset     = 1'b1;
      jump      = 1'b1;
      jump_addr = 26'h000_0055;
      stall     = 1'b1;
      tick();
      checks++;
      if ({pc, ifid_instr, ifid_pc4, ifid_valid} !== {32'h0, 32'h0, 32'h0, 1'b0}) begin
         errors++;
         $display("FAIL mid_reset: pc=%h instr=%h pc4=%h v=%b want 0/0/0/0", pc, ifid_instr, ifid_pc4, ifid_valid);
      end
      reset = 1'b0;
      clear_inputs();
      tick();
      checks++;
      if ({pc, ifid_instr, ifid_pc4, ifid_valid} !== {32'h4, 32'h20080001, 32'h4, 1'b1}) begin
         errors++;
         $display("FAIL post_reset: pc=%h instr=%h pc4=%h v=%b want 4/20080001/4/1", pc, ifid_instr, ifid_pc4, ifid_valid);
      end
`ifdef IF_PERF_CNT_EN
      checks++;
      if ({fetch_cnt, stall_cnt} !== {32'd1, 32'd0}) begin
         errors++;
         $display("FAIL post_reset_cnt: fetch=%0d stall=%0d want 1/0", fetch_cnt, stall_cnt);
      end
`endif
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 256; i++) im[i] = 32'hA000_0000 | i;
      im[0] = 32'h20080001;
      im[1] = 32'h20090002;
      im[2] = 32'h01095020;
      im[3] = 32'hAC0A0000;
      reset = 1'b1;
      clear_inputs();
      test_reset();
      test_sequential();
      test_stall();
      test_branch();
      test_jump();
      test_stall_combos();
      test_wrap_and_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
